// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multicycle multiply/divide engine.
// Optional feature macro used by muldiv_unit: MULDIV_EARLY_TERM_EN.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WIDTH_DEFAULT = 32;

  // Signed all-ones so a size cast to any operand width stays all ones.
  localparam logic signed [WIDTH_DEFAULT-1:0] DBZ_QUOTIENT = '1;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate. Used as abs() on the
// operands on entry (neg = sign bit) and to restore signs on the results.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] fixed
);

  assign fixed = neg ? (~value + 1'b1) : value;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multicycle signed WIDTHxWIDTH multiply / WIDTH/WIDTH divide with a
// start/busy/done handshake. Shift-add multiply and restoring divide on magnitudes,
// signs applied in a final FIX cycle.
// Optional feature: define MULDIV_EARLY_TERM_EN to let MUL leave RUN as soon as the
// remaining multiplier bits are all zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(DBZ_QUOTIENT);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;

  // Magnitudes are WIDTH+1 bits so that |most negative value| is representable.
  logic [WIDTH:0]     a_mag;
  logic [WIDTH:0]     b_mag;

  // Multiply datapath
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH:0]     mplier;

  // Divide datapath: quo starts as the dividend and fills with quotient bits
  logic [WIDTH:0]     divisor;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     diff;
  logic               q_bit;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic               accept;
  logic               last_iter;

  assign accept = (state == IDLE) && start;

  muldiv_sign_fix #(.W(WIDTH+1)) u_abs_a (
    .value ({a[WIDTH-1], a}),
    .neg   (a[WIDTH-1]),
    .fixed (a_mag)
  );

  muldiv_sign_fix #(.W(WIDTH+1)) u_abs_b (
    .value ({b[WIDTH-1], b}),
    .neg   (b[WIDTH-1]),
    .fixed (b_mag)
  );

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .value (acc),
    .neg   (sign_a ^ sign_b),
    .fixed (prod_s)
  );

  // On the divide-by-zero path quo still holds |a| and sign_b is 0,
  // so this instance reproduces the raw dividend for the high half.
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
    .value (quo),
    .neg   (sign_a ^ sign_b),
    .fixed (quo_s)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .value (rem),
    .neg   (sign_a),
    .fixed (rem_s)
  );

  // Restoring-divide trial subtract; the borrow (diff MSB) decides the quotient bit
  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    diff      = rem_shift - divisor;
    q_bit     = ~diff[WIDTH];
  end

  // Decide whether the current RUN edge is the final iteration
  always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
    last_iter = (cnt == CNT_W'(WIDTH-1)) || (!is_div && (mplier[WIDTH:1] == '0));
`else
    last_iter = (cnt == CNT_W'(WIDTH-1));
`endif
  end

  // Control FSM: accepts requests, sequences iterations, registers the signed result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div      <= op_div;
            sign_a      <= a[WIDTH-1];
            sign_b      <= b[WIDTH-1];
            busy        <= 1'b1;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            state       <= (op_div && (b == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last_iter) state <= FIX;
        end
        FIX: begin
          result <= is_div ? {rem_s, quo_s} : prod_s;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // Arrived straight from IDLE on a zero divisor: publish now
            result      <= {quo_s, DBZ_Q};
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Iteration datapath: load magnitudes on accept, one shift-add / trial-subtract per RUN edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
    end else if (accept) begin
      acc     <= '0;
      mcand   <= {{(WIDTH-1){1'b0}}, a_mag};
      mplier  <= b_mag;
      divisor <= b_mag;
      rem     <= '0;
      quo     <= a_mag[WIDTH-1:0];
    end else if (state == RUN) begin
      if (is_div) begin
        rem <= q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], q_bit};
      end else begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Honors MULDIV_EARLY_TERM_EN for the expected MUL latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div_by_zero;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] last_exp = 64'd0;

`ifdef MULDIV_EARLY_TERM_EN
  localparam int L_22_24  = 6;
  localparam int L_MIN_M1 = 2;
  localparam int L_MIN_MN = 33;
  localparam int L_26_1   = 2;
  localparam int L_26_0   = 2;
  localparam int L_GLITCH = 32;
  localparam int L_3_5    = 4;
`else
  localparam int L_22_24  = 33;
  localparam int L_MIN_M1 = 33;
  localparam int L_MIN_MN = 33;
  localparam int L_26_1   = 33;
  localparam int L_26_0   = 33;
  localparam int L_GLITCH = 33;
  localparam int L_3_5    = 33;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_div      (op_div),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One request: accept on E0, count edges to done, check result/flags and the done pulse.
  task automatic run_op(input string tag, input logic op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [63:0] exp_res,
                        input int exp_edges, input logic exp_dbz, input int glitch_at);
    int   edges;
    logic busy_ok;
    logic got_done;
    @(negedge clk);
    start = 1'b1; op_div = op; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check({tag, "_accept_busy"}, {63'd0, busy}, 64'd1);
    check({tag, "_hold_on_accept"}, result, last_exp);
    edges = 0; busy_ok = 1'b1; got_done = 1'b0;
    while (!got_done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (!busy) busy_ok = 1'b0;
      if (done) got_done = 1'b1;
      else if (edges == glitch_at) begin
        start = 1'b1; op_div = ~op; a = 32'd9; b = 32'd0;
      end else start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    check({tag, "_busy_through"}, {63'd0, busy_ok}, 64'd1);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, {62'd0, done, busy}, 64'd0);
    check({tag, "_result_held"}, result, exp_res);
    last_exp = exp_res;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_div = 1'b0; a = '0; b = '0;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_22_24", 1'b0, 32'd22, 32'd24, 64'h0000000000000210, L_22_24, 1'b0, -1);
    run_op("div_22_24", 1'b1, 32'd22, 32'd24, {32'd22, 32'd0}, 33, 1'b0, -1);
    run_op("div_m7_2", 1'b1, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0, -1);
    run_op("mul_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, L_MIN_M1, 1'b0, -1);
    run_op("mul_min_min", 1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000, L_MIN_MN, 1'b0, -1);
    run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33, 1'b0, -1);
    run_op("div_26_0", 1'b1, 32'd26, 32'd0, {32'd26, 32'hFFFFFFFF}, 1, 1'b1, -1);
    run_op("mul_26_1", 1'b0, 32'd26, 32'd1, 64'd26, L_26_1, 1'b0, -1);
    run_op("div_m26_0", 1'b1, -32'sd26, 32'd0, {32'hFFFFFFE6, 32'hFFFFFFFF}, 1, 1'b1, -1);
    run_op("mul_26_0", 1'b0, 32'd26, 32'd0, 64'd0, L_26_0, 1'b0, -1);
    run_op("mul_glitch", 1'b0, -32'sd5, 32'h40000001, 64'hFFFFFFFEBFFFFFFB, L_GLITCH, 1'b0, 5);

    // Asynchronous reset in the middle of a running MUL
    @(negedge clk);
    start = 1'b1; op_div = 1'b0; a = 32'd3; b = 32'h7FFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_exp = 64'd0;

    run_op("mul_3_5", 1'b0, 32'd3, 32'd5, 64'd15, L_3_5, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
